// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with run-time CPOL/CPHA, bit order and chip-select choice.
// Busy for CLK_DIV*(2*DATA_WIDTH+2) cycles per word; valid pulses on the first idle cycle after.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  parameter int CLK_DIV    = 2,
  localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  spi_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [SEL_W-1:0]      slave_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  spi_scl,
  output logic [NUM_SLAVES-1:0] spi_cs,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  valid,
  output logic                  busy
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_END  = EDGE_W'(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic                  scl_q, scl_d;
  logic                  mosi_q, mosi_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  valid_q, valid_d;
  logic                  edge_now;
  logic                  div_end;
  logic                  sel_ok;
  logic [31:0]           sel_ext;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w,
                                                       input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign sel_ext = 32'(slave_sel);
  assign sel_ok  = (sel_ext < 32'(NUM_SLAVES));
  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    edge_d   = edge_q;
    scl_d    = scl_q;
    mosi_d   = mosi_q;
    sel_d    = sel_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    lsb_d    = lsb_q;
    tx_d     = tx_q;
    rx_sh_d  = rx_sh_q;
    rx_d     = rx_q;
    valid_d  = 1'b0;
    edge_now = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && sel_ok) begin
          sel_d   = slave_sel;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          scl_d   = cpol;
          div_d   = '0;
          edge_d  = '0;
          rx_sh_d = '0;
          // cpha=0 presents the first bit before the first SCL edge
          if (cpha) begin
            tx_d = tx_data;
          end else begin
            tx_d   = shift_word(tx_data, lsb_first);
            mosi_d = first_bit(tx_data, lsb_first);
          end
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_end) begin
          div_d    = '0;
          edge_now = 1'b1;
          state_d  = S_XFER;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_XFER: begin
        if (div_end) begin
          div_d = '0;
          if (edge_q == EDGE_END) begin
            state_d = S_HOLD;
          end else begin
            edge_now = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (div_end) begin
          div_d   = '0;
          state_d = S_IDLE;
          valid_d = 1'b1;
          rx_d    = rx_sh_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // even edge index = leading edge; sampling edge is leading for cpha=0, trailing for cpha=1
    if (edge_now) begin
      scl_d  = ~scl_q;
      edge_d = edge_q + EDGE_W'(1);
      if (~edge_q[0] ^ cpha_q) begin
        rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_WIDTH-1:1]} : {rx_sh_q[DATA_WIDTH-2:0], miso};
      end else if (edge_q != EDGE_LAST) begin
        mosi_d = first_bit(tx_q, lsb_q);
        tx_d   = shift_word(tx_q, lsb_q);
      end
    end
  end

  always_ff @(posedge spi_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      scl_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sel_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      scl_q   <= scl_d;
      mosi_q  <= mosi_d;
      sel_q   <= sel_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      valid_q <= valid_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign valid   = valid_q;
  assign rx_data = rx_q;
  assign mosi    = mosi_q;
  assign spi_scl = scl_q;
  assign spi_cs  = (state_q == S_IDLE) ? '1 : ~(NUM_SLAVES'(1) << sel_q);

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default build, a 16-bit single-slave build and a 5-slave build.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // default build: 8 bits, 4 slaves, divider 2
  logic       start0, cpol0, cpha0, lsb0, miso0, mosi0, scl0, valid0, busy0, loop0;
  logic [7:0] tx0, rx0;
  logic [1:0] sel0;
  logic [3:0] cs0;

  // 16 bits, 1 slave, divider 1, loopback
  logic        start1, mosi1, scl1, valid1, busy1;
  logic [15:0] tx1, rx1;
  logic [0:0]  sel1, cs1;

  // 8 bits, 5 slaves (3-bit select), loopback
  logic       start2, mosi2, scl2, valid2, busy2;
  logic [7:0] tx2, rx2;
  logic [2:0] sel2;
  logic [4:0] cs2;

  // simple SPI slave on dut0: MSB first, mode given by slv_cpol/slv_cpha
  logic       slv_cpol = 1'b0, slv_cpha = 1'b0, slv_miso = 1'b0;
  logic [7:0] slv_word = 8'h00, slv_rx = 8'h00;
  int         slv_idx = 0;
  logic       prev_scl = 1'b0, prev_idle = 1'b1;

  assign miso0 = loop0 ? mosi0 : slv_miso;

  spi_master_param #(.DATA_WIDTH(8), .NUM_SLAVES(4), .CLK_DIV(2)) dut0 (
    .spi_clk(clk), .reset(reset), .start(start0), .tx_data(tx0), .slave_sel(sel0),
    .cpol(cpol0), .cpha(cpha0), .lsb_first(lsb0), .miso(miso0), .mosi(mosi0),
    .spi_scl(scl0), .spi_cs(cs0), .rx_data(rx0), .valid(valid0), .busy(busy0));

  spi_master_param #(.DATA_WIDTH(16), .NUM_SLAVES(1), .CLK_DIV(1)) dut1 (
    .spi_clk(clk), .reset(reset), .start(start1), .tx_data(tx1), .slave_sel(sel1),
    .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .miso(mosi1), .mosi(mosi1),
    .spi_scl(scl1), .spi_cs(cs1), .rx_data(rx1), .valid(valid1), .busy(busy1));

  spi_master_param #(.DATA_WIDTH(8), .NUM_SLAVES(5), .CLK_DIV(2)) dut2 (
    .spi_clk(clk), .reset(reset), .start(start2), .tx_data(tx2), .slave_sel(sel2),
    .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .miso(mosi2), .mosi(mosi2),
    .spi_scl(scl2), .spi_cs(cs2), .rx_data(rx2), .valid(valid2), .busy(busy2));

  always @(scl0 or cs0) begin
    if (cs0 != 4'hF && prev_idle) begin
      slv_idx = 0;
      slv_rx  = 8'h00;
      if (!slv_cpha) begin
        slv_miso = slv_word[7];
        slv_idx  = 1;
      end
    end else if (cs0 != 4'hF && scl0 != prev_scl) begin
      if ((scl0 != slv_cpol) ^ slv_cpha) begin
        slv_rx = {slv_rx[6:0], mosi0};
      end else if (slv_idx < 8) begin
        slv_miso = slv_word[7-slv_idx];
        slv_idx  = slv_idx + 1;
      end
    end
    prev_scl  = scl0;
    prev_idle = (cs0 == 4'hF);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go0(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                     input logic pha, input logic lsb);
    @(negedge clk);
    tx0 = tx; sel0 = sel; cpol0 = pol; cpha0 = pha; lsb0 = lsb;
    start0 = 1'b1;
  endtask

  // watch dut0 for ncyc cycles; optionally re-pulse start (with other config) at cycle mid_at
  task automatic win0(input int ncyc, input int mid_at, output int bcnt, output int vcnt,
                      output logic [7:0] rxc, output logic [3:0] csc, output int multi);
    bcnt = 0; vcnt = 0; rxc = 8'h00; csc = 4'hF; multi = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (busy0) bcnt++;
      if (busy0 && bcnt == 1) csc = cs0;
      if ($countones(~cs0) > 1) multi++;
      if (valid0) begin vcnt++; rxc = rx0; end
      start0 = (i == mid_at);
      if (i == mid_at) begin tx0 = 8'hFF; sel0 = 2'd3; cpha0 = 1'b1; end
    end
  endtask

  int         bc, vc, mc, v2, nv, bc1, bc_first, gap;
  logic [7:0] rxc;
  logic [3:0] csc;
  logic [15:0] r1a, r1b;

  initial begin
    reset = 1'b0; loop0 = 1'b1;
    start0 = 0; tx0 = 0; sel0 = 0; cpol0 = 0; cpha0 = 0; lsb0 = 0;
    start1 = 0; tx1 = 0; sel1 = 0;
    start2 = 0; tx2 = 0; sel2 = 0;
    #12;
    check("rst_cs", 32'(cs0), 32'hF);
    check("rst_scl", 32'(scl0), 32'h0);
    check("rst_mosi", 32'(mosi0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_valid", 32'(valid0), 32'h0);
    check("rst_rx", 32'(rx0), 32'h0);
    @(negedge clk); reset = 1'b1;

    // T1: mode 0 loopback, 0x9A to slave 0
    loop0 = 1'b1; slv_cpol = 1'b0; slv_cpha = 1'b0;
    go0(8'h9A, 2'd0, 1'b0, 1'b0, 1'b0);
    win0(40, -1, bc, vc, rxc, csc, mc);
    check("t1_busy_cycles", 32'(bc), 32'd36);
    check("t1_valid_count", 32'(vc), 32'd1);
    check("t1_rx", 32'(rxc), 32'h9A);
    check("t1_cs", 32'(csc), 32'hE);
    check("t1_mosi_bits", 32'(slv_rx), 32'h9A);
    check("t1_rx_hold", 32'(rx0), 32'h9A);

    // T2: mode 3, slave returns 0x5E
    loop0 = 1'b0; slv_cpol = 1'b1; slv_cpha = 1'b1; slv_word = 8'h5E;
    go0(8'hC3, 2'd1, 1'b1, 1'b1, 1'b0);
    win0(40, -1, bc, vc, rxc, csc, mc);
    check("t2_rx", 32'(rxc), 32'h5E);
    check("t2_slave_rx", 32'(slv_rx), 32'hC3);
    check("t2_cs", 32'(csc), 32'hD);
    check("t2_scl_idle", 32'(scl0), 32'h1);
    check("t2_valid_count", 32'(vc), 32'd1);

    // T3: LSB first, 0x01 to slave 2; slave shifts MSB-first so sees 1 then seven 0s as 0x80
    loop0 = 1'b1; slv_cpol = 1'b0; slv_cpha = 1'b0;
    go0(8'h01, 2'd2, 1'b0, 1'b0, 1'b1);
    win0(40, -1, bc, vc, rxc, csc, mc);
    check("t3_cs", 32'(csc), 32'hB);
    check("t3_rx", 32'(rxc), 32'h01);
    check("t3_mosi_order", 32'(slv_rx), 32'h80);
    check("t3_scl_idle", 32'(scl0), 32'h0);

    // T4: start re-pulsed mid-transfer is ignored
    go0(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0);
    win0(44, 10, bc, vc, rxc, csc, mc);
    check("t4_valid_count", 32'(vc), 32'd1);
    check("t4_busy_cycles", 32'(bc), 32'd36);
    check("t4_rx", 32'(rxc), 32'h3C);
    check("t4_cs_multi_low", 32'(mc), 32'd0);

    // T4b: out-of-range select on the 5-slave build, then a valid one
    @(negedge clk); sel2 = 3'd5; tx2 = 8'h5A; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    check("t4_badsel_busy", 32'(busy2), 32'h0);
    check("t4_badsel_cs", 32'(cs2), 32'h1F);
    v2 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid2 || busy2) v2++;
    end
    check("t4_badsel_quiet", 32'(v2), 32'd0);
    @(negedge clk); sel2 = 3'd4; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    check("t4_sel4_busy", 32'(busy2), 32'h1);
    check("t4_sel4_cs", 32'(cs2), 32'h0F);
    rxc = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid2) begin v2++; rxc = rx2; end
    end
    check("t4_sel4_valid", 32'(v2), 32'd1);
    check("t4_sel4_rx", 32'(rxc), 32'h5A);

    // T5: reset around bit 4 aborts the transfer
    go0(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); start0 = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("t5_cs", 32'(cs0), 32'hF);
    check("t5_scl", 32'(scl0), 32'h0);
    check("t5_busy", 32'(busy0), 32'h0);
    vc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid0) vc++;
    end
    check("t5_no_valid", 32'(vc), 32'd0);
    reset = 1'b1;
    go0(8'h66, 2'd3, 1'b0, 1'b0, 1'b0);
    win0(40, -1, bc, vc, rxc, csc, mc);
    check("t5_after_rx", 32'(rxc), 32'h66);
    check("t5_after_valid", 32'(vc), 32'd1);
    check("t5_after_cs", 32'(csc), 32'h7);

    // T6: 16-bit, divider 1, second start during the first valid cycle
    @(negedge clk); tx1 = 16'hA55A; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    nv = 0; bc1 = 0; bc_first = 0; gap = 0; r1a = 16'h0; r1b = 16'h0;
    for (int i = 0; i < 80; i++) begin
      if (busy1) bc1++;
      if (nv == 1 && cs1 == 1'b1) gap++;
      if (valid1) begin
        nv++;
        if (nv == 1) begin
          r1a = rx1; bc_first = bc1; gap++;
          tx1 = 16'h1234; start1 = 1'b1;
        end else begin
          r1b = rx1;
        end
      end else begin
        start1 = 1'b0;
      end
      @(negedge clk);
    end
    check("t6_valid_count", 32'(nv), 32'd2);
    check("t6_rx_first", 32'(r1a), 32'hA55A);
    check("t6_rx_second", 32'(r1b), 32'h1234);
    check("t6_busy_first", 32'(bc_first), 32'd34);
    check("t6_busy_total", 32'(bc1), 32'd68);
    check("t6_cs_gap", 32'(gap >= 1), 32'h1);
    check("t6_scl_idle", 32'(scl1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
